// File: rtl/count_stepper_if.sv
// Request channel of count_stepper: one "optionally clear, then advance N steps" command.
// Handshake: a request transfers on a rising clk edge where req_valid & req_ready are both 1.
interface count_stepper_if #(
    parameter int STEP_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_clear;
    logic [STEP_W-1:0] req_steps;

    modport master (output req_valid, output req_clear, output req_steps, input req_ready);
    modport slave  (input req_valid, input req_clear, input req_steps, output req_ready);
endinterface

// File: rtl/count_stepper.sv
// Turns one handshaked request into a clear/plus pulse train for a clear/plus up-counter.
// Optional macro COUNT_STEPPER_CHECK_EN: compare returned cnt_q with the shadow model in DONE.
module count_stepper #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    count_stepper_if.slave   req,
    output logic             clear,
    output logic             plus,
    input  logic [WIDTH-1:0] cnt_q,
    output logic [WIDTH-1:0] exp_q,
    output logic             done,
    output logic             err,
    output logic [1:0]       o_dbg_state,
    output logic             o_dbg_shadow_valid
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_STEP  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [STEP_W-1:0] r_remaining;
    logic [WIDTH-1:0]  r_exp_q;
    logic              r_shadow_valid;

    // All outputs decode the registered state, so clear and plus can never overlap.
    assign req.req_ready      = (r_state == S_IDLE);
    assign clear              = (r_state == S_CLEAR);
    assign plus               = (r_state == S_STEP);
    assign done               = (r_state == S_DONE);
    assign exp_q              = r_exp_q;
    assign o_dbg_state        = r_state;
    assign o_dbg_shadow_valid = r_shadow_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_remaining    <= '0;
            r_exp_q        <= '0;
            r_shadow_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req.req_valid) begin
                        r_remaining <= req.req_steps;
                        if (req.req_clear)
                            r_state <= S_CLEAR;
                        else if (req.req_steps != '0)
                            r_state <= S_STEP;
                        else
                            r_state <= S_DONE;
                    end
                end
                S_CLEAR: begin
                    r_exp_q        <= '0;
                    r_shadow_valid <= 1'b1;
                    r_state        <= (r_remaining != '0) ? S_STEP : S_DONE;
                end
                S_STEP: begin
                    r_exp_q     <= r_exp_q + WIDTH'(1);
                    r_remaining <= r_remaining - STEP_W'(1);
                    if (r_remaining == STEP_W'(1))
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef COUNT_STEPPER_CHECK_EN
    logic r_err;

    // The counter takes its last plus on the edge entering DONE, so cnt_q is settled here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if ((r_state == S_DONE) && r_shadow_valid && (cnt_q != r_exp_q))
            r_err <= 1'b1;
    end

    assign err = r_err;
`else
    logic w_unused_cnt_q;

    assign w_unused_cnt_q = ^cnt_q;
    assign err            = 1'b0;
`endif
endmodule
